// File: rtl/peridot_phy_txarb.sv
// rtl/peridot_phy_txarb.sv - round-robin arbiter of NUM_CH byte-packet sources onto one UART TX PHY; PERIDOT_TXARB_CHHEADER_EN adds a channel header byte
module peridot_phy_txarb #(
    parameter int NUM_CH       = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   in_valid,
    input  logic [8*NUM_CH-1:0] in_data,
    input  logic [NUM_CH-1:0]   in_eop,
    output logic [NUM_CH-1:0]   in_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    input  logic                out_ready,
    output logic [2:0]          grant_ch,
    output logic                busy
);

    localparam logic [15:0] TMO_LOAD = 16'(HOLD_TIMEOUT);
    localparam bit          TMO_EN   = (HOLD_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef PERIDOT_TXARB_CHHEADER_EN
        ST_HEADER,
`endif
        ST_DATA
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  rr_last;
    logic [15:0] tmo_cnt;
    logic        slot_free;
    logic        cur_valid;
    logic        cur_eop;
    logic [7:0]  cur_data;
    logic        xfer;
    logic        req_found;
    logic [2:0]  req_ch;
    logic        tmo_expire;
    logic        hdr_load;

    // The output register can take a new byte when empty or draining this cycle.
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != ST_IDLE);

    // Mux the granted channel's request and gate in_ready to that channel only.
    always_comb begin
        cur_valid = 1'b0;
        cur_eop   = 1'b0;
        cur_data  = 8'h00;
        in_ready  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_ch == 3'(i)) begin
                cur_valid   = in_valid[i];
                cur_eop     = in_eop[i];
                cur_data    = in_data[8*i +: 8];
                in_ready[i] = (state == ST_DATA) && slot_free;
            end
        end
    end

    assign xfer       = (state == ST_DATA) && cur_valid && slot_free;
    assign tmo_expire = TMO_EN && (state == ST_DATA) && !xfer && (tmo_cnt <= 16'd1);

`ifdef PERIDOT_TXARB_CHHEADER_EN
    assign hdr_load = (state == ST_HEADER) && slot_free;
`else
    assign hdr_load = 1'b0;
`endif

    // Round-robin scan: first requester after rr_last, wrapping, wins.
    always_comb begin
        req_found = 1'b0;
        req_ch    = 3'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (!req_found && in_valid[j] && (j == (int'(rr_last) + k) % NUM_CH)) begin
                    req_found = 1'b1;
                    req_ch    = 3'(j);
                end
            end
        end
    end

    // Next-state logic: grant, optional header, then data until eop or stall timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_found) begin
`ifdef PERIDOT_TXARB_CHHEADER_EN
                    state_nxt = ST_HEADER;
`else
                    state_nxt = ST_DATA;
`endif
                end
            end
`ifdef PERIDOT_TXARB_CHHEADER_EN
            ST_HEADER: begin
                if (slot_free) state_nxt = ST_DATA;
            end
`endif
            ST_DATA: begin
                if (xfer && cur_eop) state_nxt = ST_IDLE;
                else if (tmo_expire) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Grant ownership, round-robin pointer and stall timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_ch <= 3'd0;
            rr_last  <= 3'(NUM_CH - 1);
            tmo_cnt  <= 16'd0;
        end else if (state == ST_IDLE && req_found) begin
            grant_ch <= req_ch;
            rr_last  <= req_ch;
            tmo_cnt  <= TMO_LOAD;
        end else if (state == ST_DATA) begin
            if (xfer)                            tmo_cnt <= TMO_LOAD;
            else if (TMO_EN && tmo_cnt != 16'd0) tmo_cnt <= tmo_cnt - 16'd1;
        end
    end

    // Single-entry output register toward the PHY.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= cur_data;
        end else if (hdr_load) begin
            out_valid <= 1'b1;
            out_data  <= 8'hF0 | {5'b00000, grant_ch};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_peridot_phy_txarb.sv
// tb/tb_peridot_phy_txarb.sv - directed self-checking bench for peridot_phy_txarb
`timescale 1ns/1ps
module tb_peridot_phy_txarb;

`ifdef PERIDOT_TXARB_CHHEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_eop;
    logic        out_ready;

    logic [3:0]  rdy_a, rdy_b;
    logic        ov_a, ov_b, busy_a, busy_b;
    logic [7:0]  od_a, od_b;
    logic [2:0]  gr_a, gr_b;

    peridot_phy_txarb #(.NUM_CH(4), .HOLD_TIMEOUT(1024)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_eop(in_eop), .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a),
        .out_ready(out_ready), .grant_ch(gr_a), .busy(busy_a)
    );

    peridot_phy_txarb #(.NUM_CH(4), .HOLD_TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_eop(in_eop), .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b),
        .out_ready(out_ready), .grant_ch(gr_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit          use_b;
    logic [3:0]  m_rdy;
    logic        m_ov, m_busy;
    logic [7:0]  m_od;
    logic [2:0]  m_gr;
    assign m_rdy  = use_b ? rdy_b  : rdy_a;
    assign m_ov   = use_b ? ov_b   : ov_a;
    assign m_od   = use_b ? od_b   : od_a;
    assign m_gr   = use_b ? gr_b   : gr_a;
    assign m_busy = use_b ? busy_b : busy_a;

    logic [8:0]  src_mem [4][16];
    int          src_len [4];
    int          src_ptr [4];
    logic [3:0]  src_en;

    logic [7:0]  obs[$];
    logic [7:0]  exp_q[$];

    logic        ov_log   [64];
    logic [7:0]  od_log   [64];
    logic        busy_log [64];
    logic [3:0]  rdy_log  [64];
    logic [2:0]  gr_log   [64];
    int          cyc;

    int checks;
    int errors;

    task automatic clear_src();
        for (int c = 0; c < 4; c++) begin
            src_len[c] = 0;
            src_ptr[c] = 0;
        end
        src_en = 4'b0000;
    endtask

    task automatic push_byte(input int c, input logic [7:0] d, input logic e);
        src_mem[c][src_len[c]] = {e, d};
        src_len[c]++;
    endtask

    task automatic tick(input logic rst, input logic ordy);
        logic [3:0] acc;
        @(negedge clk);
        reset     = rst;
        out_ready = ordy;
        for (int c = 0; c < 4; c++) begin
            if (src_en[c] && src_ptr[c] < src_len[c]) begin
                in_valid[c]       = 1'b1;
                in_data[8*c +: 8] = src_mem[c][src_ptr[c]][7:0];
                in_eop[c]         = src_mem[c][src_ptr[c]][8];
            end else begin
                in_valid[c]       = 1'b0;
                in_data[8*c +: 8] = 8'h00;
                in_eop[c]         = 1'b0;
            end
        end
        #1;
        acc = in_valid & m_rdy;
        if (m_ov && out_ready) obs.push_back(m_od);
        if (cyc < 64) begin
            ov_log[cyc]   = m_ov;
            od_log[cyc]   = m_od;
            busy_log[cyc] = m_busy;
            rdy_log[cyc]  = m_rdy;
            gr_log[cyc]   = m_gr;
        end
        for (int c = 0; c < 4; c++) if (acc[c]) src_ptr[c]++;
        cyc++;
    endtask

    task automatic start_test();
        clear_src();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        obs.delete();
        exp_q.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        use_b = 0;
        clear_src();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++; if (ov_a !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got %b want 0", ov_a); end
        checks++; if (od_a !== 8'h00)   begin errors++; $display("FAIL reset_out_data got %h want 00", od_a); end
        checks++; if (rdy_a !== 4'h0)   begin errors++; $display("FAIL reset_in_ready got %b want 0000", rdy_a); end
        checks++; if (gr_a !== 3'd0)    begin errors++; $display("FAIL reset_grant got %0d want 0", gr_a); end
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (ov_b !== 1'b0)    begin errors++; $display("FAIL reset_b_out_valid got %b want 0", ov_b); end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL idle_no_req_busy got %b want 0", busy_a); end
    endtask

    task automatic test_basic();
        use_b = 0;
        start_test();
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        src_en = 4'b0010;
        for (int t = 0; t < 10; t++) tick(1'b0, 1'b1);
        checks++; if (rdy_log[0] !== 4'b0000)     begin errors++; $display("FAIL basic_rdy_t0 got %b want 0000", rdy_log[0]); end
        checks++; if (gr_log[1] !== 3'd1)         begin errors++; $display("FAIL basic_grant got %0d want 1", gr_log[1]); end
        checks++; if (rdy_log[1+HDR] !== 4'b0010) begin errors++; $display("FAIL basic_rdy got %b want 0010", rdy_log[1+HDR]); end
        checks++; if (ov_log[1] !== 1'b0)         begin errors++; $display("FAIL basic_ov_t1 got %b want 0", ov_log[1]); end
        checks++; if ({ov_log[2+HDR], od_log[2+HDR]} !== {1'b1, 8'h11})
            begin errors++; $display("FAIL basic_first_out got %b/%h want 1/11", ov_log[2+HDR], od_log[2+HDR]); end
        checks++; if (busy_log[3+HDR] !== 1'b1)   begin errors++; $display("FAIL basic_busy_hold got %b want 1", busy_log[3+HDR]); end
        checks++; if (busy_log[4+HDR] !== 1'b0)   begin errors++; $display("FAIL basic_busy_fall got %b want 0", busy_log[4+HDR]); end
        if (HDR != 0) exp_q.push_back(8'hF1);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_round_robin();
        use_b = 0;
        start_test();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) begin
                push_byte(c, 8'((c << 4) | (p << 1)), 1'b0);
                push_byte(c, 8'((c << 4) | (p << 1) | 1), 1'b1);
            end
        src_en = 4'b1111;
        for (int t = 0; t < 8*(3+HDR) + 6; t++) tick(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            checks++; if (gr_log[1 + (3+HDR)*k] !== 3'(k % 4))
                begin errors++; $display("FAIL rr_grant%0d got %0d want %0d", k, gr_log[1 + (3+HDR)*k], k % 4); end
        end
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) begin
                if (HDR != 0) exp_q.push_back(8'(8'hF0 | c));
                exp_q.push_back(8'((c << 4) | (p << 1)));
                exp_q.push_back(8'((c << 4) | (p << 1) | 1));
            end
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL rr_len got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rr_byte%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        use_b = 0;
        start_test();
        push_byte(2, 8'h21, 1'b0);
        push_byte(2, 8'h22, 1'b0);
        push_byte(2, 8'h23, 1'b1);
        src_en = 4'b0100;
        for (int t = 0; t < 20; t++) tick(1'b0, !(t >= 2+HDR && t <= 11+HDR));
        for (int t = 2+HDR; t <= 11+HDR; t++) begin
            checks++; if ({ov_log[t], od_log[t], rdy_log[t]} !== {1'b1, 8'h21, 4'b0000})
                begin errors++; $display("FAIL bp_hold_t%0d got %b/%h/%b want 1/21/0000", t, ov_log[t], od_log[t], rdy_log[t]); end
        end
        checks++; if (od_log[13+HDR] !== 8'h22) begin errors++; $display("FAIL bp_resume got %h want 22", od_log[13+HDR]); end
        if (HDR != 0) exp_q.push_back(8'hF2);
        exp_q.push_back(8'h21); exp_q.push_back(8'h22); exp_q.push_back(8'h23);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        use_b = 1;
        start_test();
        push_byte(0, 8'hA5, 1'b0);
        push_byte(0, 8'hA6, 1'b1);
        push_byte(3, 8'h3C, 1'b0);
        push_byte(3, 8'h3D, 1'b1);
        src_en = 4'b1001;
        for (int t = 0; t < 22 + 2*HDR; t++) begin
            if (t >= 2+HDR) src_en[0] = 1'b0;
            tick(1'b0, 1'b1);
        end
        checks++; if (rdy_log[1+HDR] !== 4'b0001) begin errors++; $display("FAIL tmo_rdy0 got %b want 0001", rdy_log[1+HDR]); end
        checks++; if (busy_log[9+HDR] !== 1'b1)   begin errors++; $display("FAIL tmo_busy_before got %b want 1", busy_log[9+HDR]); end
        checks++; if (busy_log[10+HDR] !== 1'b0)  begin errors++; $display("FAIL tmo_release got %b want 0", busy_log[10+HDR]); end
        checks++; if (gr_log[10+HDR] !== 3'd0)    begin errors++; $display("FAIL tmo_grant_held got %0d want 0", gr_log[10+HDR]); end
        checks++; if (gr_log[11+HDR] !== 3'd3)    begin errors++; $display("FAIL tmo_grant_move got %0d want 3", gr_log[11+HDR]); end
        if (HDR != 0) exp_q.push_back(8'hF0);
        exp_q.push_back(8'hA5);
        if (HDR != 0) exp_q.push_back(8'hF3);
        exp_q.push_back(8'h3C); exp_q.push_back(8'h3D);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL tmo_len got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL tmo_byte%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
        use_b = 0;
    endtask

    task automatic test_reset_mid();
        use_b = 0;
        start_test();
        push_byte(1, 8'h5A, 1'b0);
        push_byte(1, 8'h5B, 1'b1);
        src_en = 4'b0010;
        for (int t = 0; t <= 2+HDR; t++) tick(1'b0, t < 2+HDR);
        checks++; if ({ov_a, od_a} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rmid_pending got %b/%h want 1/5a", ov_a, od_a); end
        tick(1'b1, 1'b0);
        clear_src();
        push_byte(0, 8'h07, 1'b1);
        push_byte(1, 8'h17, 1'b1);
        src_en = 4'b0011;
        obs.delete();
        tick(1'b0, 1'b1);
        checks++; if (ov_a !== 1'b0)   begin errors++; $display("FAIL rmid_out_valid got %b want 0", ov_a); end
        checks++; if (rdy_a !== 4'h0)  begin errors++; $display("FAIL rmid_in_ready got %b want 0000", rdy_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy_a); end
        tick(1'b0, 1'b1);
        checks++; if ({busy_a, gr_a} !== {1'b1, 3'd0}) begin errors++; $display("FAIL rmid_next_grant got %b/%0d want 1/0", busy_a, gr_a); end
        for (int t = 0; t < 12; t++) tick(1'b0, 1'b1);
        if (HDR != 0) exp_q.push_back(8'hF0);
        exp_q.push_back(8'h07);
        if (HDR != 0) exp_q.push_back(8'hF1);
        exp_q.push_back(8'h17);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_len got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_byte%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_single_byte();
        use_b = 0;
        start_test();
        push_byte(2, 8'h01, 1'b1);
        src_en = 4'b0100;
        for (int t = 0; t < 8; t++) tick(1'b0, 1'b1);
        checks++; if (rdy_log[1+HDR] !== 4'b0100) begin errors++; $display("FAIL single_rdy got %b want 0100", rdy_log[1+HDR]); end
        checks++; if (busy_log[1+HDR] !== 1'b1)   begin errors++; $display("FAIL single_busy got %b want 1", busy_log[1+HDR]); end
        checks++; if (busy_log[2+HDR] !== 1'b0)   begin errors++; $display("FAIL single_idle got %b want 0", busy_log[2+HDR]); end
        checks++; if ({ov_log[2+HDR], od_log[2+HDR]} !== {1'b1, 8'h01})
            begin errors++; $display("FAIL single_out got %b/%h want 1/01", ov_log[2+HDR], od_log[2+HDR]); end
        if (HDR != 0) exp_q.push_back(8'hF2);
        exp_q.push_back(8'h01);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL single_len got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        use_b     = 0;
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b0000;
        in_data   = 32'h0;
        in_eop    = 4'b0000;
        clear_src();
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_single_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
